// File: rtl/packet_recovery_pw_if.sv
// Stream bus for packet_recovery_pw: framed input beats in, recovered beats,
// framing markers and CRC status out.
interface packet_recovery_pw_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 resync;
  logic                 valid_in;
  logic [DATA_W-1:0]    data_in;
  logic                 valid_out;
  logic [DATA_W-1:0]    data_out;
  logic                 sop_out;
  logic                 eop_out;
  logic                 crc_valid;
  logic                 crc_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output resync, valid_in, data_in,
    input  valid_out, data_out, sop_out, eop_out, crc_valid, crc_err, err_cnt
  );
  modport slave (
    input  resync, valid_in, data_in,
    output valid_out, data_out, sop_out, eop_out, crc_valid, crc_err, err_cnt
  );
endinterface

// File: rtl/packet_recovery_pw.sv
// Beat-parallel packet framer: CRC over each payload, check against the trailing
// field, overwrite that field with SYNC_WORD. One registered stage, no backpressure.
module packet_recovery_pw #(
  parameter int                  DATA_W    = 8,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'h47,
  parameter int                  PKT_BITS  = 1504,
  parameter logic [SYNC_LEN-1:0] CRC_POLY  = 8'hD5,
  parameter logic [SYNC_LEN-1:0] CRC_INIT  = 8'h00,
  parameter int                  ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_recovery_pw_if.slave  bus
);
  localparam int BEATS  = PKT_BITS / DATA_W;
  localparam int FBEATS = SYNC_LEN / DATA_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FLD_B  = CNT_W'(BEATS - FBEATS);

  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [SYNC_LEN-1:0]  crc_q, crc_d;
  logic [SYNC_LEN-1:0]  rx_fld_q, rx_fld_d;
  logic                 valid_out_q, valid_out_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 sop_q, sop_d, eop_q, eop_d;
  logic                 crc_valid_q, crc_valid_d;
  logic                 crc_err_q, crc_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [CNT_W-1:0]           eff, fk;
  logic [SYNC_LEN-1:0]        crc_base, rx_base, rx_full, sw_sh;
  logic [SYNC_LEN+DATA_W-1:0] rx_cat;
  logic                       mism;

  function automatic logic [SYNC_LEN-1:0] crc_fold(input logic [SYNC_LEN-1:0] c_in,
                                                   input logic [DATA_W-1:0]   d);
    logic [SYNC_LEN-1:0] c;
    logic                fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[SYNC_LEN-1] ^ d[i];
      c  = {c[SYNC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    crc_d       = crc_q;
    rx_fld_d    = rx_fld_q;
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    crc_valid_d = 1'b0;
    crc_err_d   = crc_err_q;
    err_cnt_d   = err_cnt_q;
    // resync makes the current beat (if any) beat 0 of a fresh window
    eff      = bus.resync ? '0 : beat_cnt_q;
    crc_base = bus.resync ? CRC_INIT : crc_q;
    rx_base  = bus.resync ? '0 : rx_fld_q;
    rx_cat   = {rx_base, bus.data_in};
    rx_full  = rx_cat[SYNC_LEN-1:0];
    fk       = eff - FLD_B;
    sw_sh    = SYNC_WORD << (fk * DATA_W);
    mism     = crc_base != rx_full;
    if (bus.resync) begin
      beat_cnt_d = '0;
      crc_d      = CRC_INIT;
      rx_fld_d   = '0;
    end
    if (bus.valid_in) begin
      valid_out_d = 1'b1;
      sop_d       = (eff == '0);
      beat_cnt_d  = (eff == LAST_B) ? '0 : eff + 1'b1;
      if (eff < FLD_B) begin
        crc_d      = crc_fold(crc_base, bus.data_in);
        data_out_d = bus.data_in;
      end else begin
        data_out_d = sw_sh[SYNC_LEN-1 -: DATA_W];
        rx_fld_d   = rx_full;
        if (eff == LAST_B) begin
          eop_d       = 1'b1;
          crc_valid_d = 1'b1;
          crc_err_d   = mism;
          crc_d       = CRC_INIT;
          rx_fld_d    = '0;
          if (mism && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      rx_fld_q    <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      crc_q       <= crc_d;
      rx_fld_q    <= rx_fld_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      crc_valid_q <= crc_valid_d;
      crc_err_q   <= crc_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
